// File: rtl/weight_loader_wq_weight_mmap_axi_pkg.sv
// Shared AXI read-channel constants and the per-beat tag carried alongside R data.
package weight_loader_wq_weight_mmap_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } beat_tag_t;

endpackage

// File: rtl/weight_loader_wq_weight_mmap_s_axi_r_skid.sv
// Two-entry R-channel buffer with registered outputs; occupancy feeds the issue credit.
module weight_loader_wq_weight_mmap_s_axi_r_skid
  import weight_loader_wq_weight_mmap_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  beat_tag_t             in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output beat_tag_t             out_tag,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] data1;
  beat_tag_t             tag1;
  logic                  pop;

  assign pop = out_valid & out_ready;

  // Entry 0 is the output register; entry 1 only fills while entry 0 is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      data1     <= '0;
      tag1      <= '0;
      occupancy <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b11: begin
          if (occupancy == 2'd2) begin
            out_data <= data1;
            out_tag  <= tag1;
            data1    <= in_data;
            tag1     <= in_tag;
          end else begin
            out_data <= in_data;
            out_tag  <= in_tag;
          end
        end
        2'b10: begin
          if (occupancy == 2'd0) begin
            out_data  <= in_data;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
          end else begin
            data1 <= in_data;
            tag1  <= in_tag;
          end
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          out_data  <= data1;
          out_tag   <= tag1;
          out_valid <= (occupancy == 2'd2);
          occupancy <= occupancy - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/weight_loader_wq_weight_mmap_s_axi_rd_responder.sv
// AXI4 read responder: one INCR burst at a time, served from a preloadable sync RAM.
//  state | meaning
//  IDLE  | arready high, waiting for an AR handshake
//  BURST | issuing RAM reads under credit, draining R beats until the last handshake
module weight_loader_wq_weight_mmap_s_axi_rd_responder
  import weight_loader_wq_weight_mmap_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [ADDR_WIDTH-1:0]        s_araddr,
  input  logic [ID_WIDTH-1:0]          s_arid,
  input  logic [7:0]                   s_arlen,
  input  logic [2:0]                   s_arsize,
  input  logic [1:0]                   s_arburst,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [DATA_WIDTH-1:0]        s_rdata,
  output logic [ID_WIDTH-1:0]          s_rid,
  output logic [1:0]                   s_rresp,
  output logic                         s_rlast,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  err_q;
  logic [8:0]            issue_cnt;
  logic [7:0]            ret_cnt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  pipe_v;
  beat_tag_t             pipe_tag;

  logic [1:0]            skid_occ;
  beat_tag_t             out_tag;
  logic                  r_pop;
  logic                  issue;
  logic [2:0]            held_after_pop;
  logic [ADDR_WIDTH-1:0] rd_addr;
  beat_tag_t             issue_tag;
  logic [DATA_WIDTH-1:0] push_data;

  assign r_pop          = s_rvalid & s_rready;
  // Counting this cycle's pop lets a full-rate drain keep one beat in flight each cycle.
  assign held_after_pop = 3'(skid_occ) + 3'(pipe_v) - 3'(r_pop);
  assign issue          = (state == BURST) && (issue_cnt <= {1'b0, len_q}) && (held_after_pop < 3'd2);
  assign rd_addr        = base_q + ADDR_WIDTH'(issue_cnt);

  always_comb begin
    issue_tag.last = (issue_cnt[7:0] == len_q);
    if (err_q)
      issue_tag.resp = RESP_SLVERR;
    else if (rd_addr >= ADDR_WIDTH'(MEM_DEPTH))
      issue_tag.resp = RESP_DECERR;
    else
      issue_tag.resp = RESP_OKAY;
  end

  // Read-first: a same-cycle preload write is not visible to the read.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    if (issue)
      ram_q <= mem[rd_addr[MEM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s_arready <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      base_q    <= '0;
      err_q     <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      pipe_v    <= 1'b0;
      pipe_tag  <= '0;
    end else begin
      pipe_v <= issue;
      if (issue) begin
        pipe_tag  <= issue_tag;
        issue_cnt <= issue_cnt + 9'd1;
      end
      case (state)
        IDLE: begin
          if (s_arvalid && s_arready) begin
            id_q      <= s_arid;
            len_q     <= s_arlen;
            base_q    <= ADDR_WIDTH'(s_araddr >> SIZE_LOG2);
            err_q     <= (s_arsize != 3'(SIZE_LOG2)) || (s_arburst != BURST_INCR);
            issue_cnt <= '0;
            ret_cnt   <= '0;
            s_arready <= 1'b0;
            state     <= BURST;
          end else begin
            s_arready <= 1'b1;
          end
        end
        BURST: begin
          if (r_pop) begin
            ret_cnt <= ret_cnt + 8'd1;
            if (ret_cnt == len_q) begin
              state     <= IDLE;
              s_arready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push_data = (pipe_tag.resp == RESP_OKAY) ? ram_q : '0;

  weight_loader_wq_weight_mmap_s_axi_r_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_r_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pipe_v),
    .in_data   (push_data),
    .in_tag    (pipe_tag),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_data  (s_rdata),
    .out_tag   (out_tag),
    .occupancy (skid_occ)
  );

  assign s_rresp = out_tag.resp;
  assign s_rlast = out_tag.last;
  assign s_rid   = id_q;

endmodule
